ram_dma: RTL and testbench

Block copy/fill engine that acts as the initiator on the single-port RAM interface (load, address, in, out). It accepts one command at a time, then drives the RAM's address/data/write-enable itself to either copy a run of words from a source region to a destination region, or fill a destination region with a constant. It sits between the CPU and data memory; while it is busy it owns the RAM port, and the top level muxes the port to it.

---
 rtl/ram_dma_pkg.sv | 17 +
 rtl/ram_dma_if.sv | 28 ++
 rtl/ram_dma.sv | 100 ++++++++++
 tb/tb_ram_dma.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the ram_dma block copy/fill engine.
package ram_dma_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 15;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_dma_if.sv
// Command/status and RAM-port bundle for ram_dma; the engine is the RAM bus master.
interface ram_dma_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 15
);
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH:0]   len;
    logic [WIDTH-1:0]      fill_value;
    logic                  busy;
    logic                  done;
    logic                  mem_load;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [WIDTH-1:0]      mem_in;
    logic [WIDTH-1:0]      mem_out;

    modport master (
        input  start, mode, src, dst, len, fill_value, mem_out,
        output busy, done, mem_load, mem_address, mem_in
    );

    modport slave (
        output start, mode, src, dst, len, fill_value, mem_out,
        input  busy, done, mem_load, mem_address, mem_in
    );
endinterface

// File: rtl/ram_dma.sv
// Block copy/fill engine driving a single-port RAM: ascending copy (two cycles
// per word) or constant fill (one cycle per word), one command at a time.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    ram_dma_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

    state_t                state_reg, state_next;
    logic                  mode_reg, mode_next;
    logic [ADDR_WIDTH-1:0] src_ptr_reg, src_ptr_next;
    logic [ADDR_WIDTH-1:0] dst_ptr_reg, dst_ptr_next;
    logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
    logic [WIDTH-1:0]      data_reg, data_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b0;
            src_ptr_reg   <= '0;
            dst_ptr_reg   <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            src_ptr_reg   <= src_ptr_next;
            dst_ptr_reg   <= dst_ptr_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
        end
    end

    // In fill mode the constant is parked in data_reg, so WRITE always drives data_reg.
    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        src_ptr_next    = src_ptr_reg;
        dst_ptr_next    = dst_ptr_reg;
        remaining_next  = remaining_reg;
        data_next       = data_reg;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.mem_load    = 1'b0;
        bus.mem_address = '0;
        bus.mem_in      = '0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mode_next      = bus.mode;
                    src_ptr_next   = bus.src;
                    dst_ptr_next   = bus.dst;
                    remaining_next = bus.len;
                    data_next      = bus.fill_value;
                    if (bus.len == CNT_ZERO)
                        state_next = DONE;
                    else if (bus.mode == MODE_COPY)
                        state_next = READ;
                    else
                        state_next = WRITE;
                end
            end
            READ: begin
                bus.busy        = 1'b1;
                bus.mem_address = src_ptr_reg;
                data_next       = bus.mem_out;
                state_next      = WRITE;
            end
            WRITE: begin
                bus.busy        = 1'b1;
                bus.mem_load    = 1'b1;
                bus.mem_address = dst_ptr_reg;
                bus.mem_in      = data_reg;
                remaining_next  = remaining_reg - CNT_ONE;
                src_ptr_next    = src_ptr_reg + PTR_ONE;
                dst_ptr_next    = dst_ptr_reg + PTR_ONE;
                if (remaining_reg == CNT_ONE)
                    state_next = DONE;
                else if (mode_reg == MODE_COPY)
                    state_next = READ;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: directed table, corner sequences and random
// commands checked against an array-based memory model.
module tb_ram_dma;
    import ram_dma_pkg::*;

    localparam int W     = 16;
    localparam int AW    = 15;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ram_dma_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    ram_dma #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [W-1:0] pat(input int i);
        logic [31:0] t;
        t = i * 40503 + 7;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    // RAM model: combinational read, write at rising edge; bench preload port has priority.
    logic [W-1:0]  mem [0:DEPTH-1];
    logic          ram_ready = 1'b0;
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [W-1:0]  pl_data;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
            ram_ready <= 1'b1;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_load) begin
            mem[bus.mem_address] <= bus.mem_in;
        end
    end

    assign bus.mem_out = mem[bus.mem_address];

    logic [W-1:0] ref_mem [0:DEPTH-1];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          mode;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        logic [W-1:0]  fill;
        int            exp_lat;
        int            exp_wr;
        logic [AW-1:0] probe_addr;
        logic [W-1:0]  probe_val;
        string         name;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic mem_compare(input string tag);
        int errs;
        int first;
        errs  = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_mem: %0d words differ, first addr %0h got %0h expected %0h",
                     tag, errs, first, mem[first], ref_mem[first]);
        end else begin
            $display("ok   %s_mem: memory matches model", tag);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        @(negedge clk);
        pl_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic run_cmd(input logic md, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] n, input logic [W-1:0] fv,
                           input int exp_lat, input int exp_wr, input int restart_cyc,
                           input string tag);
        logic [AW-1:0] exp_addr [$];
        logic [W-1:0]  exp_data [$];
        logic [31:0]   r;
        int cyc, wr, lat;
        bit seq_ok, busy_ok, outs_ok, post_ok;

        // Reference: words are moved one at a time in ascending order, addresses modulo 2^AW.
        for (int k = 0; k < int'(n); k++) begin
            logic [AW-1:0] sa, da;
            logic [W-1:0]  v;
            sa = s + AW'(k);
            da = d + AW'(k);
            v  = (md == MODE_FILL) ? fv : ref_mem[sa];
            ref_mem[da] = v;
            exp_addr.push_back(da);
            exp_data.push_back(v);
        end

        @(negedge clk);
        bus.mode = md; bus.src = s; bus.dst = d; bus.len = n; bus.fill_value = fv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        r = $urandom;
        bus.mode = r[31]; bus.src = r[14:0]; bus.dst = r[29:15]; bus.len = {1'b0, r[14:0]};
        bus.fill_value = r[25:10];

        cyc = 1; wr = 0; lat = 0;
        seq_ok = 1'b1; busy_ok = 1'b1; outs_ok = 1'b1;
        while (cyc <= 70000) begin
            if (cyc == restart_cyc) begin
                bus.start = 1'b1; bus.mode = MODE_FILL; bus.dst = 15'h5000; bus.len = 16'd4;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.mem_load) begin
                if (wr >= exp_addr.size())
                    seq_ok = 1'b0;
                else if (bus.mem_address !== exp_addr[wr] || bus.mem_in !== exp_data[wr] ||
                         cyc != ((md == MODE_FILL) ? wr + 1 : 2 * (wr + 1)))
                    seq_ok = 1'b0;
                wr++;
            end
            if (bus.done) begin
                lat = cyc;
                if (bus.busy || bus.mem_load || bus.mem_address != '0 || bus.mem_in != '0)
                    outs_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end

        post_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done || bus.busy || bus.mem_load) post_ok = 1'b0;
        end

        chk({tag, "_done_cycle"}, longint'(lat), longint'(exp_lat));
        chk({tag, "_writes"}, longint'(wr), longint'(exp_wr));
        chk({tag, "_write_seq"}, longint'(seq_ok), 64'd1);
        chk({tag, "_busy"}, longint'(busy_ok), 64'd1);
        chk({tag, "_done_outs"}, longint'(outs_ok), 64'd1);
        chk({tag, "_idle_after"}, longint'(post_ok), 64'd1);
        mem_compare(tag);
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill_value = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);

        vecs[0] = '{MODE_FILL, 15'h0000, 15'h0010, 16'd4, 16'hBEEF, 5, 4, 15'h0014, pat(32'h14), "fill4"};
        vecs[1] = '{MODE_COPY, 15'h0100, 15'h0200, 16'd3, 16'h0000, 7, 3, 15'h0201, 16'h2222, "copy3"};
        vecs[2] = '{MODE_COPY, 15'h0000, 15'h0001, 16'd2, 16'h0000, 5, 2, 15'h0002, 16'h0005, "overlap"};
        vecs[3] = '{MODE_FILL, 15'h0000, 15'h7FFE, 16'd3, 16'h00AA, 4, 3, 15'h0001, 16'h0005, "wrap"};
        vecs[4] = '{MODE_FILL, 15'h0000, 15'h0050, 16'd0, 16'hFFFF, 1, 0, 15'h0050, pat(32'h50), "len0"};
        vecs[5] = '{MODE_COPY, 15'h7FFF, 15'h0010, 16'd1, 16'h0000, 3, 1, 15'h0010, 16'h00AA, "copy_top"};

        #1 reset = 1'b1;
        #1 chk("reset_outs", longint'({bus.busy, bus.done, bus.mem_load, bus.mem_address, bus.mem_in}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", longint'({bus.busy, bus.done, bus.mem_load, bus.mem_address, bus.mem_in}), 64'd0);

        preload(15'h0100, 16'h1111);
        preload(15'h0101, 16'h2222);
        preload(15'h0102, 16'h3333);
        preload(15'h0000, 16'h0005);
        preload(15'h0001, 16'h0006);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill,
                    vecs[i].exp_lat, vecs[i].exp_wr, 0, vecs[i].name);
            chk({vecs[i].name, "_probe"}, longint'(mem[vecs[i].probe_addr]), longint'(vecs[i].probe_val));
        end

        // A start pulse while busy, and one during DONE, must both be dropped.
        run_cmd(MODE_FILL, 15'h0000, 15'h0600, 16'd4, 16'hC0DE, 5, 4, 2, "restart_busy");
        run_cmd(MODE_FILL, 15'h0000, 15'h0700, 16'd4, 16'hD00D, 5, 4, 5, "restart_done");

        begin : rst_mid
            bit quiet;
            @(negedge clk);
            bus.mode = MODE_COPY; bus.src = 15'h0300; bus.dst = 15'h0400; bus.len = 16'd4;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("rst_second_read", longint'({bus.busy, bus.mem_load, bus.mem_address}),
                longint'({1'b1, 1'b0, 15'h0301}));
            reset = 1'b1;
            #1 chk("rst_outs", longint'({bus.busy, bus.done, bus.mem_load, bus.mem_address, bus.mem_in}), 64'd0);
            quiet = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (bus.done) quiet = 1'b0;
            end
            reset = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.done || bus.busy || bus.mem_load) quiet = 1'b0;
            end
            chk("rst_quiet", longint'(quiet), 64'd1);
            ref_mem[15'h0400] = ref_mem[15'h0300];
            mem_compare("rst");
        end
        run_cmd(MODE_FILL, 15'h0000, 15'h0800, 16'd5, 16'h7777, 6, 5, 0, "after_rst");

        run_cmd(MODE_FILL, 15'h0000, 15'h1234, 16'h8000, 16'h1234, 32769, 32768, 0, "full");

        for (int t = 0; t < 24; t++) begin
            logic [31:0]   r1, r2;
            logic          md;
            logic [AW-1:0] s, d;
            logic [AW:0]   n;
            int            lat;
            r1 = $urandom;
            r2 = $urandom;
            md = r1[0];
            n  = 16'($urandom_range(0, 24));
            s  = r1[15:1];
            d  = r2[14:0];
            if (r2[31]) d = 15'h7FF8 + {11'b0, r2[18:15]};
            if (r1[31]) d = s + {10'b0, r2[23:19]};
            lat = (n == 0) ? 1 : ((md == MODE_FILL) ? int'(n) + 1 : 2 * int'(n) + 1);
            run_cmd(md, s, d, n, r2[30:15], lat, int'(n), 0, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
